mac_sequencer: RTL and testbench

//   Initiator side of the mac operand interface: takes two packed operand vectors and drives A/B/y/nReset of a mac instance.
//   It clears the accumulator, streams N_TERMS operand pairs (one per clock), then captures the 8-bit dot product.

---
 rtl/mac_sequencer_pkg.sv | 15 +
 rtl/mac_sequencer_launch_reg.sv | 43 ++++
 rtl/mac_sequencer.sv | 148 ++++++++++++++
 tb/tb_mac_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the mac sequencer: FSM state encodings and the
// operand/accumulator width defaults it shares with the mac datapath.
package mac_sequencer_pkg;

    localparam int DEF_N_TERMS = 4;
    localparam int DEF_OP_W    = 2;
    localparam int DEF_ACC_W   = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/mac_sequencer_launch_reg.sv
// Falling-edge register bank that launches the mac operand/control pins, so
// they never move while the gated mac clock (clk & y) can be high.
module mac_launch_reg import mac_sequencer_pkg::*; #(
    parameter int OP_W = DEF_OP_W
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [OP_W-1:0] a_d_i,
    input  logic [OP_W-1:0] b_d_i,
    input  logic            y_d_i,
    input  logic            nrst_d_i,
    output logic [OP_W-1:0] a_o,
    output logic [OP_W-1:0] b_o,
    output logic            y_o,
    output logic            nrst_o
);

    logic [OP_W-1:0] a_q;
    logic [OP_W-1:0] b_q;
    logic            y_q;
    logic            nrst_q;

    // Reset load leaves the mac idle: accumulate disabled and accumulator held clear.
    always_ff @(negedge clk_i) begin
        if (reset_i) begin
            a_q    <= '0;
            b_q    <= '0;
            y_q    <= 1'b0;
            nrst_q <= 1'b0;
        end else begin
            a_q    <= a_d_i;
            b_q    <= b_d_i;
            y_q    <= y_d_i;
            nrst_q <= nrst_d_i;
        end
    end

    assign a_o    = a_q;
    assign b_o    = b_q;
    assign y_o    = y_q;
    assign nrst_o = nrst_q;

endmodule

// File: rtl/mac_sequencer.sv
// Initiator for a mac instance: clears it, streams N_TERMS operand pairs, then
// captures the dot product and compares it against an internally kept shadow sum.
module mac_sequencer import mac_sequencer_pkg::*; #(
    parameter int N_TERMS = DEF_N_TERMS,
    parameter int OP_W    = DEF_OP_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [N_TERMS*OP_W-1:0] vec_a_i,
    input  logic [N_TERMS*OP_W-1:0] vec_b_i,
    input  logic [ACC_W-1:0]        acc_in_i,
    output logic [OP_W-1:0]         mac_a_o,
    output logic [OP_W-1:0]         mac_b_o,
    output logic                    mac_y_o,
    output logic                    mac_nrst_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [ACC_W-1:0]        result_o,
    output logic                    chk_err_o
);

    localparam int              K_W    = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int              SH_W   = ACC_W + 1;
    localparam int              PROD_W = 2 * OP_W;
    localparam logic [K_W-1:0]  K_LAST = K_W'(N_TERMS - 1);

    logic [2:0]              state_q,   state_d;
    logic [K_W-1:0]          termIdx_q, termIdx_d;
    logic [N_TERMS*OP_W-1:0] vecA_q,    vecA_d;
    logic [N_TERMS*OP_W-1:0] vecB_q,    vecB_d;
    logic [SH_W-1:0]         shadow_q,  shadow_d;
    logic [ACC_W-1:0]        result_q,  result_d;
    logic                    chkErr_q,  chkErr_d;
    logic                    inReset_q;

    logic [31:0]             termBase;
    logic [OP_W-1:0]         termA, termB;
    logic [PROD_W-1:0]       termProd;
    logic [OP_W-1:0]         launchA, launchB;
    logic                    launchY, launchNrst;

    assign termBase = 32'(termIdx_q) * 32'(OP_W);
    assign termA    = vecA_q[termBase +: OP_W];
    assign termB    = vecB_q[termBase +: OP_W];
    assign termProd = PROD_W'(termA) * PROD_W'(termB);

    // DONE also accepts start so a back-to-back run begins on the edge it retires.
    always_comb begin
        state_d   = state_q;
        termIdx_d = termIdx_q;
        vecA_d    = vecA_q;
        vecB_d    = vecB_q;
        shadow_d  = shadow_q;
        result_d  = result_q;
        chkErr_d  = chkErr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d  = S_CLEAR;
                    vecA_d   = vec_a_i;
                    vecB_d   = vec_b_i;
                    shadow_d = '0;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_d   = S_FEED;
                termIdx_d = '0;
            end
            S_FEED: begin
                shadow_d = shadow_q + SH_W'(termProd);
                if (termIdx_q == K_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    termIdx_d = termIdx_q + K_W'(1);
                end
            end
            S_DRAIN: begin
                state_d  = S_DONE;
                result_d = acc_in_i;
                chkErr_d = (acc_in_i != shadow_q[ACC_W-1:0]) || shadow_q[ACC_W];
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        inReset_q <= reset_i;
        if (reset_i) begin
            state_q   <= S_IDLE;
            termIdx_q <= '0;
            vecA_q    <= '0;
            vecB_q    <= '0;
            shadow_q  <= '0;
            result_q  <= '0;
            chkErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            termIdx_q <= termIdx_d;
            vecA_q    <= vecA_d;
            vecB_q    <= vecB_d;
            shadow_q  <= shadow_d;
            result_q  <= result_d;
            chkErr_q  <= chkErr_d;
        end
    end

    // Pin values for the half cycle after the next falling edge, decoded from the current state.
    always_comb begin
        launchA    = '0;
        launchB    = '0;
        launchY    = 1'b0;
        launchNrst = 1'b1;
        case (state_q)
            S_IDLE, S_CLEAR: launchNrst = 1'b0;
            S_FEED: begin
                launchY = 1'b1;
                launchA = termA;
                launchB = termB;
            end
            default: launchNrst = 1'b1;
        endcase
    end

    mac_launch_reg #(
        .OP_W(OP_W)
    ) u_launch (
        .clk_i   (clk_i),
        .reset_i (inReset_q),
        .a_d_i   (launchA),
        .b_d_i   (launchB),
        .y_d_i   (launchY),
        .nrst_d_i(launchNrst),
        .a_o     (mac_a_o),
        .b_o     (mac_b_o),
        .y_o     (mac_y_o),
        .nrst_o  (mac_nrst_o)
    );

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign result_o  = result_q;
    assign chk_err_o = chkErr_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboarded bench for mac_sequencer driving a behavioural mac (clk gated by y,
// async active-low clear); expected runs come from a dot-product reference model.
module tb_mac_sequencer;

    localparam int N     = 4;
    localparam int OP_W  = 2;
    localparam int ACC_W = 8;
    localparam int VW    = N * OP_W;

    typedef struct {
        logic [ACC_W-1:0] res;
        logic             err;
        int               doneCycle;
    } expT;

    logic             clk     = 1'b0;
    logic             reset   = 1'b1;
    logic             start   = 1'b0;
    logic [VW-1:0]    vecA    = '0;
    logic [VW-1:0]    vecB    = '0;
    logic             corrupt = 1'b0;
    logic [ACC_W-1:0] macAcc;
    logic [ACC_W-1:0] accIn;
    logic [OP_W-1:0]  macA, macB;
    logic             macY, macNrst, busy, done, chkErr;
    logic [ACC_W-1:0] result;

    expT sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cycle = 0;
    int  nextAccept = 0;
    int  lastAccept = -1000;
    bit  monitorOn = 1'b0;

    always #5 clk = ~clk;

    mac_sequencer #(.N_TERMS(N), .OP_W(OP_W), .ACC_W(ACC_W)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .vec_a_i   (vecA),
        .vec_b_i   (vecB),
        .acc_in_i  (accIn),
        .mac_a_o   (macA),
        .mac_b_o   (macB),
        .mac_y_o   (macY),
        .mac_nrst_o(macNrst),
        .busy_o    (busy),
        .done_o    (done),
        .result_o  (result),
        .chk_err_o (chkErr)
    );

    // Behavioural mac: accumulates on clk & y, cleared asynchronously by nReset.
    always @(posedge clk or negedge macNrst) begin
        if (!macNrst)  macAcc <= '0;
        else if (macY) macAcc <= macAcc + ACC_W'(macA) * ACC_W'(macB);
    end
    assign accIn = macAcc ^ ACC_W'(corrupt);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic expT refRun(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic cor, input int c0);
        expT r;
        int  sum = 0;
        for (int k = 0; k < N; k++)
            sum += int'(a[k*OP_W +: OP_W]) * int'(b[k*OP_W +: OP_W]);
        r.res       = ACC_W'(sum) ^ ACC_W'(cor);
        r.err       = cor || (sum >= (1 << ACC_W));
        r.doneCycle = c0 + N + 2;
        return r;
    endfunction

    // Reference: a start is taken when the previous run has retired; done lands N+2 edges later.
    initial forever begin
        @(posedge clk);
        cycle++;
        if (reset) begin
            sb.delete();
            nextAccept = cycle + 1;
            lastAccept = -1000;
        end else if (start && cycle >= nextAccept) begin
            sb.push_back(refRun(vecA, vecB, corrupt, cycle));
            lastAccept = cycle;
            nextAccept = cycle + N + 3;
        end
    end

    initial forever begin
        expT e;
        bit  expDone;
        @(negedge clk);
        if (monitorOn) begin
            checkOutput("busy", 32'(busy), 32'(cycle >= lastAccept && cycle <= lastAccept + N + 2));
            expDone = (sb.size() > 0) && (sb[0].doneCycle == cycle);
            checkOutput("done", 32'(done), 32'(expDone));
            if (expDone) begin
                e = sb.pop_front();
                checkOutput("result", 32'(result), 32'(e.res));
                checkOutput("chk_err", 32'(chkErr), 32'(e.err));
            end
        end
    end

    // Launch pins may only move on falling edges, i.e. while clk is low.
    always @(macA or macB or macY or macNrst) begin
        if (monitorOn) begin
            checks++;
            if (clk !== 1'b0) begin
                errors++;
                $display("[TB] FAIL glitch: launch pin moved with clk=%b at cycle %0d", clk, cycle);
            end
        end
    end

    task automatic applyStimulus(input logic [VW-1:0] a, input logic [VW-1:0] b);
        vecA  = a;
        vecB  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vecA  = VW'($urandom);
        vecB  = VW'($urandom);
    endtask

    task automatic waitIdle();
        repeat (N + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_chk_err", 32'(chkErr), 32'd0);
        @(negedge clk); #1;
        checkOutput("rst_mac_nrst", 32'(macNrst), 32'd0);
        checkOutput("rst_mac_y", 32'(macY), 32'd0);
        checkOutput("rst_acc_in", 32'(accIn), 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        monitorOn = 1'b1;

        applyStimulus(8'he4, 8'hff);
        waitIdle();
        checkOutput("idle_acc_in", 32'(accIn), 32'd0);
        applyStimulus(8'hff, 8'hff);
        waitIdle();
        applyStimulus(8'h55, 8'h55);
        waitIdle();

        vecA  = VW'($urandom);
        vecB  = VW'($urandom);
        start = 1'b1;
        for (int i = 0; i < 2 * (N + 3); i++) begin
            @(posedge clk); #1;
            vecA = VW'($urandom);
            vecB = VW'($urandom);
        end
        start = 1'b0;
        waitIdle();

        applyStimulus(VW'($urandom), VW'($urandom));
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(8'hff, 8'hff);
        waitIdle();

        applyStimulus(8'hff, 8'hff);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        @(negedge clk); #1;
        checkOutput("abort_mac_y", 32'(macY), 32'd0);
        checkOutput("abort_mac_nrst", 32'(macNrst), 32'd0);
        @(posedge clk); #1;
        applyStimulus(8'h9c, 8'h6b);
        waitIdle();

        corrupt = 1'b1;
        applyStimulus(VW'($urandom), VW'($urandom));
        waitIdle();
        corrupt = 1'b0;

        for (int r = 0; r < 24; r++) begin
            applyStimulus(VW'($urandom), VW'($urandom));
            repeat ($urandom_range(N + 4, N + 1)) @(posedge clk);
            #1;
        end
        waitIdle();

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
